// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: parametrised, pipelined Wallace-tree multiplier with valid/ready on both sides.
// Optional macro WALLACE_SIGNED_EN adds sgn_i and a Baugh-Wooley two's-complement mode.
module wallace_mult_pipe #(
    parameter int XW   = 9,
    parameter int YW   = 4,
    parameter int PIPE = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [XW-1:0]    x_i,
    input  logic [YW-1:0]    y_i,
`ifdef WALLACE_SIGNED_EN
    input  logic             sgn_i,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XW+YW-1:0] product_o
);

    localparam int W = XW + YW;
`ifdef WALLACE_SIGNED_EN
    localparam int NROW = YW + 1;
    // Baugh-Wooley correction 2^(XW-1) + 2^(YW-1) + 2^(W-1), taken modulo 2^W.
    localparam logic [W-1:0] KCORR = W'((64'd1 << (XW - 1)) + (64'd1 << (YW - 1)) + (64'd1 << (W - 1)));
`else
    localparam int NROW = YW;
`endif

    function automatic int rows_at(input int lvl);
        int c;
        c = NROW;
        for (int k = 0; k < lvl; k++) c = (c / 3) * 2 + c % 3;
        return c;
    endfunction

    function automatic int num_lvls(input int c0);
        int c;
        int n;
        c = c0;
        n = 0;
        while (c > 2) begin
            c = (c / 3) * 2 + c % 3;
            n++;
        end
        return n;
    endfunction

    localparam int NLVL = num_lvls(NROW);

    logic         advance;
    logic [W-1:0] pp_d [NROW];
    logic [W-1:0] tree_in [NROW];
    logic         v_tree;
    logic [W-1:0] cpa_a, cpa_b;
    logic         v_cpa;
    logic [W-1:0] product_d, product_q;
    logic         out_valid_q;

    assign advance     = !out_valid_q || out_ready_i;
    assign in_ready_o  = advance;
    assign out_valid_o = out_valid_q;
    assign product_o   = product_q;

    always_comb begin
        for (int j = 0; j < NROW; j++) pp_d[j] = '0;
        for (int j = 0; j < YW; j++) begin
            for (int i = 0; i < XW; i++) begin
`ifdef WALLACE_SIGNED_EN
                pp_d[j][i+j] = (x_i[i] & y_i[j]) ^ (sgn_i & ((i == XW - 1) != (j == YW - 1)));
`else
                pp_d[j][i+j] = x_i[i] & y_i[j];
`endif
            end
        end
`ifdef WALLACE_SIGNED_EN
        pp_d[YW] = sgn_i ? KCORR : '0;
`endif
    end

    generate
        if (PIPE == 3) begin : g_pp_reg
            logic [W-1:0] pp_q [NROW];
            logic         v_pp_q;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    pp_q   <= '{default: '0};
                    v_pp_q <= 1'b0;
                end else if (advance) begin
                    pp_q   <= pp_d;
                    v_pp_q <= in_valid_i;
                end
            end
            assign tree_in = pp_q;
            assign v_tree  = v_pp_q;
        end else begin : g_pp_comb
            assign tree_in = pp_d;
            assign v_tree  = in_valid_i;
        end
    endgenerate

    // Each level compresses rows in groups of three; leftover rows pass straight down.
    generate
        for (genvar l = 0; l <= NLVL; l++) begin : lev
            logic [W-1:0] r [rows_at(l)];
            if (l == 0) begin : g_root
                assign r = tree_in;
            end else begin : g_csa
                localparam int NP = rows_at(l - 1);
                localparam int NG = NP / 3;
                for (genvar g = 0; g < NG; g++) begin : fa
                    assign r[2*g]   = lev[l-1].r[3*g] ^ lev[l-1].r[3*g+1] ^ lev[l-1].r[3*g+2];
                    assign r[2*g+1] = ((lev[l-1].r[3*g]   & lev[l-1].r[3*g+1]) |
                                       (lev[l-1].r[3*g]   & lev[l-1].r[3*g+2]) |
                                       (lev[l-1].r[3*g+1] & lev[l-1].r[3*g+2])) << 1;
                end
                for (genvar p = 0; p < NP % 3; p++) begin : pass
                    assign r[2*NG+p] = lev[l-1].r[3*NG+p];
                end
            end
        end
    endgenerate

    generate
        if (PIPE >= 2) begin : g_row_reg
            logic [W-1:0] sum_q, carry_q;
            logic         v_row_q;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sum_q   <= '0;
                    carry_q <= '0;
                    v_row_q <= 1'b0;
                end else if (advance) begin
                    sum_q   <= lev[NLVL].r[0];
                    carry_q <= lev[NLVL].r[1];
                    v_row_q <= v_tree;
                end
            end
            assign cpa_a = sum_q;
            assign cpa_b = carry_q;
            assign v_cpa = v_row_q;
        end else begin : g_row_comb
            assign cpa_a = lev[NLVL].r[0];
            assign cpa_b = lev[NLVL].r[1];
            assign v_cpa = v_tree;
        end
    endgenerate

    assign product_d = cpa_a + cpa_b;

    // Bubbles leave product_q untouched so it keeps the last real result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (advance) begin
            out_valid_q <= v_cpa;
            if (v_cpa) product_q <= product_d;
        end
    end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Scoreboard bench for wallace_mult_pipe: three parameter sets, directed and random traffic.
// With WALLACE_SIGNED_EN defined the bench also drives sgn_i and checks signed products.
module tb_wallace_mult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] x_d;
    logic [11:0] y_d;
    logic        iv_d;
    logic        orr_d;
`ifdef WALLACE_SIGNED_EN
    logic        s_d;
    logic        s_next;
`endif
    int          cur;

    logic        ir0, ov0, ir1, ov1, ir2, ov2;
    logic [12:0] p0;
    logic [15:0] p1;
    logic [27:0] p2;

    wallace_mult_pipe #(.XW(9), .YW(4), .PIPE(2)) dut0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv_d && cur == 0), .in_ready_o(ir0),
        .x_i(x_d[8:0]), .y_i(y_d[3:0]),
`ifdef WALLACE_SIGNED_EN
        .sgn_i(s_d),
`endif
        .out_valid_o(ov0), .out_ready_i(orr_d || cur != 0), .product_o(p0));

    wallace_mult_pipe #(.XW(8), .YW(8), .PIPE(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv_d && cur == 1), .in_ready_o(ir1),
        .x_i(x_d[7:0]), .y_i(y_d[7:0]),
`ifdef WALLACE_SIGNED_EN
        .sgn_i(s_d),
`endif
        .out_valid_o(ov1), .out_ready_i(orr_d || cur != 1), .product_o(p1));

    wallace_mult_pipe #(.XW(16), .YW(12), .PIPE(3)) dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv_d && cur == 2), .in_ready_o(ir2),
        .x_i(x_d), .y_i(y_d),
`ifdef WALLACE_SIGNED_EN
        .sgn_i(s_d),
`endif
        .out_valid_o(ov2), .out_ready_i(orr_d || cur != 2), .product_o(p2));

    logic        mon_ov, mon_ir;
    logic [27:0] mon_p;
    always_comb begin
        mon_ov = ov0;
        mon_ir = ir0;
        mon_p  = {15'd0, p0};
        case (cur)
            1: begin mon_ov = ov1; mon_ir = ir1; mon_p = {12'd0, p1}; end
            2: begin mon_ov = ov2; mon_ir = ir2; mon_p = p2; end
            default: ;
        endcase
    end

    typedef struct {
        logic [27:0] p;
        int          t;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit lat_chk = 1'b0;
    bit or_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int xw_f(input int k);
        return (k == 0) ? 9 : (k == 1) ? 8 : 16;
    endfunction
    function automatic int yw_f(input int k);
        return (k == 0) ? 4 : (k == 1) ? 8 : 12;
    endfunction
    function automatic int pipe_f(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 3;
    endfunction

    // Reference: plain integer multiply, operands reinterpreted as signed when requested.
    function automatic logic [27:0] model(input int k, input logic [15:0] xv, input logic [11:0] yv, input logic sv);
        longint a, b, pr, m;
        int xw, yw;
        xw = xw_f(k);
        yw = yw_f(k);
        a  = longint'(xv);
        b  = longint'(yv);
        if (sv && xv[xw-1]) a = a - (longint'(1) << xw);
        if (sv && yv[yw-1]) b = b - (longint'(1) << yw);
        pr = a * b;
        m  = (longint'(1) << (xw + yw)) - 1;
        return 28'(pr & m);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (or_rand) orr_d = ($urandom_range(0, 3) != 0);
    end

    // Monitor: every cycle with out_valid the product must match the head of the scoreboard.
    initial forever begin
        @(negedge clk);
        #4;
        if (rst) begin
            sb.delete();
        end else begin
            chk("in_ready", mon_ir, !mon_ov || orr_d);
            if (mon_ov) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", mon_ov, 1'b0);
                end else begin
                    chk("product", mon_p, sb[0].p);
                    if (orr_d) begin
                        if (lat_chk) chk("latency", cyc - sb[0].t, pipe_f(cur));
                        sb.delete(0);
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] xv, input logic [11:0] yv, input logic [27:0] ev);
        int n;
        n = 0;
        @(negedge clk);
        iv_d = 1'b1;
        x_d  = xv;
        y_d  = yv;
`ifdef WALLACE_SIGNED_EN
        s_d  = s_next;
`endif
        #4;
        while (!mon_ir && n < 200) begin
            n++;
            @(negedge clk);
            #4;
        end
        if (mon_ir) sb.push_back('{p: ev, t: cyc});
        else chk("accept_timeout", mon_ir, 1'b1);
    endtask

    task automatic idle();
        @(negedge clk);
        iv_d = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle();
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_run(input int k, input int n);
        logic [15:0] xv;
        logic [11:0] yv;
        logic        sv;
        @(negedge clk);
        cur     = k;
        lat_chk = 1'b0;
        or_rand = 1'b1;
        for (int i = 0; i < n; i++) begin
            xv = 16'($urandom) & 16'((32'd1 << xw_f(k)) - 1);
            yv = 12'($urandom) & 12'((32'd1 << yw_f(k)) - 1);
            sv = 1'b0;
`ifdef WALLACE_SIGNED_EN
            sv     = 1'($urandom_range(0, 1));
            s_next = sv;
`endif
            if ($urandom_range(0, 3) == 0) idle();
            send(xv, yv, model(k, xv, yv, sv));
        end
        drain();
        or_rand = 1'b0;
        orr_d   = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        iv_d  = 1'b0;
        orr_d = 1'b1;
        x_d   = '0;
        y_d   = '0;
        cur   = 0;
`ifdef WALLACE_SIGNED_EN
        s_d    = 1'b0;
        s_next = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #4;
        chk("reset_out_valid", ov0, 1'b0);
        chk("reset_product", p0, 13'd0);
        chk("reset_in_ready", ir0, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        lat_chk = 1'b1;
        send(16'd511, 12'd15, 28'h1DF1);
        drain();

        send(16'd0, 12'd15, 28'd0);
        send(16'd511, 12'd0, 28'd0);
        drain();

        lat_chk = 1'b0;
        fork
            begin
                logic [15:0] xv;
                logic [11:0] yv;
                for (int i = 0; i < 5; i++) begin
                    xv = 16'($urandom_range(0, 511));
                    yv = 12'($urandom_range(0, 15));
                    send(xv, yv, model(0, xv, yv, 1'b0));
                end
                idle();
            end
            begin
                repeat (3) @(negedge clk);
                orr_d = 1'b0;
                repeat (3) @(negedge clk);
                orr_d = 1'b1;
            end
        join
        drain();

        send(16'd100, 12'd9, 28'd900);
        send(16'd200, 12'd3, 28'd600);
        @(negedge clk);
        iv_d = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #4;
            chk("no_out_after_rst", ov0, 1'b0);
        end
        lat_chk = 1'b1;
        send(16'd3, 12'd5, 28'd15);
        drain();

`ifdef WALLACE_SIGNED_EN
        s_next = 1'b1;
        send(16'h1FF, 12'hF, 28'h0001);
        send(16'h100, 12'h7, 28'h1900);
        s_next = 1'b0;
        send(16'h1FF, 12'hF, 28'h1DF1);
        drain();
`endif

        rand_run(0, 200);
        rand_run(1, 200);
        rand_run(2, 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
